// File: rtl/qsfp_multipage_poller.sv
// Sweeps a page table over the I2C master TFR stream and mirrors each read byte into a
// shadow RAM at {page_idx, byte}; pauses into a host command bypass when poll_en drops.
module qsfp_multipage_poller #(
  parameter logic [6:0]             DEV_ADDR   = 7'h50,
  parameter int                     NUM_PAGES  = 5,
  parameter logic [NUM_PAGES*8-1:0] PAGE_LIST  = {8'h21, 8'h20, 8'h03, 8'h02, 8'h00},
  parameter int                     PIDX_W     = 3,
  parameter int                     RX_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              poll_en,
  input  logic [31:0]       delay_cycles,
  output logic [9:0]        cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [9:0]        csr_cmd_data,
  input  logic              csr_cmd_valid,
  output logic              csr_cmd_ready,
  output logic              shd_wren,
  output logic [PIDX_W+7:0] shd_addr,
  output logic [7:0]        shd_wdata,
  output logic              fsm_paused,
  output logic              sweep_done,
  output logic [15:0]       sweep_count,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(RX_TIMEOUT + 1);
  localparam logic [PIDX_W-1:0] LAST_PIDX = PIDX_W'(NUM_PAGES - 1);

  typedef enum logic [3:0] {
    IDLE, PG_CTRL, PG_REG, PG_SEL, DELAY, AD_CTRL, AD_REG,
    RD_CTRL, RD_CMD, RD_WAIT, TO_STOP, NEXT, PAUSED
  } state_t;

  state_t            state, state_nxt, ret, ret_nxt;
  logic [PIDX_W-1:0] pidx, pidx_nxt;
  logic [8:0]        byte_cnt, byte_nxt;
  logic [31:0]       dly, dly_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [9:0]        cmd_data_r;
  logic              cmd_valid_r;
  logic              poll_q;
  logic              done_nxt, err_set, hs, paused;

  function automatic logic is_send(state_t s);
    return (s == PG_CTRL) || (s == PG_REG) || (s == PG_SEL) || (s == AD_CTRL) ||
           (s == AD_REG) || (s == RD_CTRL) || (s == RD_CMD) || (s == TO_STOP);
  endfunction

  // Word for the command issued in state s, evaluated with the page/byte it will use.
  function automatic logic [9:0] cmd_word(state_t s, logic [PIDX_W-1:0] p, logic [8:0] b);
    logic [9:0] w;
    w = 10'h000;
    case (s)
      PG_CTRL, AD_CTRL: w = {2'b10, DEV_ADDR, 1'b0};
      PG_REG:           w = 10'h07F;
      PG_SEL:           w = {2'b01, PAGE_LIST[{p, 3'b000} +: 8]};
      AD_REG:           w = {2'b00, (p == '0) ? 8'h00 : 8'h80};
      RD_CTRL:          w = {2'b10, DEV_ADDR, 1'b1};
      RD_CMD:           w = (b == 9'd255) ? 10'h100 : 10'h000;
      TO_STOP:          w = 10'h100;
      default:          w = 10'h000;
    endcase
    return w;
  endfunction

  assign paused        = (state == PAUSED);
  assign fsm_paused    = paused;
  assign hs            = cmd_valid_r & cmd_ready;
  assign cmd_valid     = paused ? csr_cmd_valid : cmd_valid_r;
  assign cmd_data      = paused ? csr_cmd_data : cmd_data_r;
  assign csr_cmd_ready = paused & cmd_ready;
  assign rx_ready      = (state == RD_WAIT);

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    pidx_nxt  = pidx;
    byte_nxt  = byte_cnt;
    dly_nxt   = dly;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:    state_nxt = poll_en ? PG_CTRL : PAUSED;
      PG_CTRL: if (hs) state_nxt = PG_REG;
      PG_REG:  if (hs) state_nxt = PG_SEL;
      PG_SEL: if (hs) begin
        state_nxt = DELAY;
        dly_nxt   = delay_cycles;
        ret_nxt   = AD_CTRL;
      end
      DELAY: begin
        if (dly == 32'd0) state_nxt = ret;
        else              dly_nxt   = dly - 32'd1;
      end
      AD_CTRL: begin
        byte_nxt = (pidx == '0) ? 9'd0 : 9'd128;
        if (hs) state_nxt = AD_REG;
      end
      AD_REG:  if (hs) state_nxt = RD_CTRL;
      RD_CTRL: if (hs) state_nxt = RD_CMD;
      RD_CMD:  if (hs) state_nxt = RD_WAIT;
      // A byte arriving on the timeout cycle still counts.
      RD_WAIT: begin
        if (rx_valid) begin
          if (byte_cnt == 9'd255) begin
            state_nxt = NEXT;
          end else begin
            byte_nxt  = byte_cnt + 9'd1;
            state_nxt = RD_CMD;
          end
        end else if (to_cnt == TO_W'(RX_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          state_nxt = TO_STOP;
        end
      end
      TO_STOP: if (hs) begin
        state_nxt = DELAY;
        dly_nxt   = delay_cycles;
        ret_nxt   = PG_CTRL;
      end
      NEXT: begin
        if (pidx == LAST_PIDX) begin
          pidx_nxt = '0;
          done_nxt = 1'b1;
        end else begin
          pidx_nxt = pidx + 1'b1;
        end
        if (!poll_en) begin
          state_nxt = PAUSED;
        end else begin
          state_nxt = DELAY;
          dly_nxt   = delay_cycles;
          ret_nxt   = PG_CTRL;
        end
      end
      // Only reachable with poll_en low, so a level test here is a rising edge.
      PAUSED: if (poll_en && !csr_cmd_valid) begin
        pidx_nxt  = '0;
        state_nxt = PG_CTRL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ret         <= IDLE;
      pidx        <= '0;
      byte_cnt    <= '0;
      dly         <= '0;
      to_cnt      <= '0;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= '0;
      shd_wren    <= 1'b0;
      shd_addr    <= '0;
      shd_wdata   <= '0;
      sweep_done  <= 1'b0;
      sweep_count <= '0;
      err_timeout <= 1'b0;
      poll_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      pidx       <= pidx_nxt;
      byte_cnt   <= byte_nxt;
      dly        <= dly_nxt;
      to_cnt     <= (state == RD_WAIT) ? to_cnt + 1'b1 : '0;
      poll_q     <= poll_en;
      sweep_done <= done_nxt;
      if (done_nxt) sweep_count <= sweep_count + 16'd1;
      if (err_set)                   err_timeout <= 1'b1;
      else if (poll_en && !poll_q)   err_timeout <= 1'b0;
      // Next command is staged in the same cycle the previous one is accepted.
      if (!cmd_valid_r || cmd_ready) begin
        cmd_valid_r <= is_send(state_nxt);
        cmd_data_r  <= is_send(state_nxt) ? cmd_word(state_nxt, pidx_nxt, byte_nxt) : 10'h000;
      end
      shd_wren <= (state == RD_WAIT) && rx_valid;
      if ((state == RD_WAIT) && rx_valid) begin
        shd_addr  <= {pidx, byte_cnt[7:0]};
        shd_wdata <= rx_data;
      end
    end
  end

endmodule

// File: doc/qsfp_multipage_poller.md
Name: qsfp_multipage_poller

Overview:
- Parametrised successor to the single-module QSFP poller.
- Autonomously sweeps a configurable list of QSFP/CMIS pages over an Avalon-ST command stream into the I2C master's TFR interface. Each received byte is written into a shadow RAM addressed {page_index, byte_addr}.
- Adds a generic page table, a configurable device address, an RX timeout with recovery, sweep accounting and a CSR command bypass while paused.

Parameters:
- DEV_ADDR, 7'h50, 7-bit I2C device address of the module.
- NUM_PAGES, 5, number of page-table entries (1..16).
- PAGE_LIST, {8'h21,8'h20,8'h03,8'h02,8'h00}, packed NUM_PAGES*8 page numbers; entry 0 is in bits [7:0].
- PIDX_W, 3, page-index width; must satisfy 2**PIDX_W >= NUM_PAGES.
- RX_TIMEOUT, 4096, cycles allowed in RD_WAIT before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- poll_en  in  1  level; 1 = autonomous polling, 0 = pause and CSR bypass.
- delay_cycles  in  32  settle delay applied after each page select and each page read.
- cmd_data  out  10  TFR word: [9] START, [8] STOP, [7:0] byte.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  I2C master accepts command.
- rx_data  in  8  read byte from the I2C master RX FIFO.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  poller accepts rx byte.
- csr_cmd_data  in  10  host TFR word (bypass path).
- csr_cmd_valid  in  1  host command valid.
- csr_cmd_ready  out  1  host command accepted.
- shd_wren  out  1  shadow RAM write strobe.
- shd_addr  out  PIDX_W+8  shadow RAM address {page_idx, byte}.
- shd_wdata  out  8  shadow RAM data.
- fsm_paused  out  1  1 while in PAUSED.
- sweep_done  out  1  1-cycle pulse after the last entry completes.
- sweep_count  out  16  completed sweeps; wraps at 16'hFFFF -> 0.
- err_timeout  out  1  sticky RX timeout flag; cleared by reset or by a poll_en rising edge.

Behaviour:
- Reset is asynchronous and active-high. State = IDLE; all outputs 0; page_idx = 0; the delay counter and timeout counter are 0.
- Command handshake:
  - cmd_* are driven from registers. Once cmd_valid is raised, cmd_data is held until the cycle in which cmd_valid&cmd_ready.
  - The following command may present on the next cycle at the earliest.
- The byte address counter is 9 bits wide, so it never wraps.
  - Entry 0 reads bytes 0..255 (256 bytes).
  - Every other entry reads bytes 128..255 (128 bytes).
- States and transitions:
  - IDLE: poll_en=1 -> PG_CTRL; else -> PAUSED.
  - PG_CTRL: send {1,0,DEV_ADDR,0} (0x2A0 at the default address).
  - PG_REG: send 0x07F.
  - PG_SEL: send {0,1,PAGE_LIST[page_idx]} (STOP asserted); then load delay_cycles -> DELAY, return target AD_CTRL.
  - DELAY: decrement each cycle; when the count is 0, go to the return target. A delay_cycles value of 0 spends exactly 1 cycle in DELAY.
  - AD_CTRL: send 0x2A0.
  - AD_REG: send {2'b00, start_addr}, where start_addr = 0 for entry 0 and 128 otherwise.
  - RD_CTRL: send {1,0,DEV_ADDR,1} (0x2A1, repeated START).
  - RD_CMD: send 0x000, or 0x100 (STOP/NACK) when the current byte is the last byte of the entry.
  - RD_WAIT: rx_ready=1. On rx_valid, assert shd_wren for 1 cycle with shd_addr={page_idx, byte[7:0]} and shd_wdata=rx_data.
    - If not the last byte: increment byte -> RD_CMD.
    - If the last byte: -> NEXT.
  - NEXT: page_idx increments; wrapping from NUM_PAGES-1 to 0 pulses sweep_done and increments sweep_count.
    - If poll_en=0: -> PAUSED.
    - Otherwise load delay_cycles -> DELAY, return target PG_CTRL.
  - PAUSED: fsm_paused=1 and csr_cmd_* pass through combinationally to cmd_* (csr_cmd_ready = cmd_ready).
    - A poll_en rising edge is accepted only when no bypass command is pending; it resets page_idx to 0 -> PG_CTRL.
    - sweep_count is preserved across the pause.
- Pause boundary:
  - poll_en is sampled only in IDLE, NEXT and PAUSED.
  - Deasserting poll_en mid-transaction finishes the current entry, so the bus always ends with a STOP.
- Timeout:
  - The RD_WAIT counter is reset on entry to RD_WAIT.
  - Reaching RX_TIMEOUT sets err_timeout and issues 0x100 (terminating STOP).
  - The poller then loads the delay and retries the same page_idx from PG_CTRL; bytes already written are not rolled back.
- Simultaneous rx_valid and timeout in the same cycle: the byte wins and no error is flagged.
- rx_valid outside RD_WAIT is ignored (rx_ready=0). csr_cmd_ready=0 outside PAUSED.

Test Plan:
- Defaults, poll_en=1, cmd_ready=1, delay_cycles=0, rx returns byte_addr^8'h5A each time:
  - first commands are 0x2A0, 0x07F, 0x100, 0x2A0, 0x000, 0x2A1;
  - 256 shadow writes to addresses 0..255;
  - the last read command is 0x100.
- Full sweep: page selects 0x100, 0x102, 0x103, 0x120, 0x121 in order; 768 total shd_wren; sweep_done pulses once; sweep_count=1; entry 4 writes at addresses 0x480..0x4FF.
- Drop poll_en during entry 1 byte 140: entry 1 completes through byte 255, then fsm_paused=1. A host csr_cmd 0x2A0 appears on cmd_data with cmd_ready backpressure of 3 cycles, and csr_cmd_ready mirrors cmd_ready.
- Re-raise poll_en: a 0x100 page select (entry 0) follows; err_timeout clears; sweep_count is unchanged.
- Withhold rx_valid for RX_TIMEOUT cycles at entry 2 byte 130: err_timeout=1, a 0x100 command is issued, and entry 2 restarts with a 0x103 page select.
- delay_cycles=10 with cmd_ready toggling every cycle: exactly 11 idle cycles follow the page-select handshake, and cmd_data stays stable while cmd_valid&!cmd_ready.
- Assert reset mid RD_WAIT: all outputs go to 0 asynchronously; after release, the sweep restarts from PG_CTRL, entry 0.
